cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the experiment CPU. It owns the program counter and the instruction register, and steps every instruction through fetch, decode, execute, memory and write-back. It drives the enables for the register file, ALU and data memory, and handshakes with the data memory. It sits between instruction memory (combinational, addressed by `pc`) and the datapath, replacing the free-running counter.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_sequencer.sv | 111 +++++++++++
 tb/tb_cpu_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, sequencer states, fault codes and instruction field extraction.
// Imported by the sequencer, the datapath and the instruction memory.
package cpu_pkg;

    localparam logic [5:0] OP_ALU   = 6'h00;
    localparam logic [5:0] OP_LOAD  = 6'h04;
    localparam logic [5:0] OP_STORE = 6'h05;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_PAUSE,
        S_HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'd0,
        FAULT_ILLEGAL = 2'd1,
        FAULT_TIMEOUT = 2'd2
    } fault_t;

    function automatic logic [5:0] get_op(input logic [31:0] ir);
        return ir[5:0];
    endfunction

    function automatic logic [4:0] get_rd(input logic [31:0] ir);
        return ir[12:8];
    endfunction

    function automatic logic [4:0] get_addr(input logic [31:0] ir);
        return ir[17:13];
    endfunction

    function automatic logic [4:0] get_rt(input logic [31:0] ir);
        return ir[22:18];
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns PC and IR and steps each instruction through
// fetch/decode/execute/memory/write-back, driving datapath enables and the data-memory handshake.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                step_mode,
    input  logic [31:0]         instr,
    input  logic                mem_ack,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         ir,
    output logic                alu_en,
    output logic                rf_we,
    output logic                rf_wsel,
    output logic                mem_req,
    output logic                mem_we,
    output logic                busy,
    output logic                halted,
    output logic [1:0]          fault
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    seq_state_t          w_retire_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_ir;
    logic [7:0]          r_wait;
    fault_t              r_fault;
    fault_t              w_fault_set;
    logic [5:0]          w_op;

    assign w_op           = get_op(r_ir);
    assign w_retire_state = step_mode ? S_PAUSE : S_FETCH;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        w_next_state = r_state;
        w_fault_set  = FAULT_NONE;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_ALU:            w_next_state = S_EXEC;
                    OP_LOAD, OP_STORE: w_next_state = S_MEM;
                    OP_HALT:           w_next_state = S_HALT;
                    default: begin
                        w_next_state = S_HALT;
                        w_fault_set  = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_EXEC:   w_next_state = S_WB;
            S_MEM: begin
                // An ack in the final allowed cycle still completes the access.
                if (mem_ack) begin
                    w_next_state = (w_op == OP_LOAD) ? S_WB : w_retire_state;
                end else if (r_wait == TIMEOUT_CNT) begin
                    w_next_state = S_HALT;
                    w_fault_set  = FAULT_TIMEOUT;
                end
            end
            S_WB:     w_next_state = w_retire_state;
            S_PAUSE:  if (start) w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_wait  <= '0;
            r_fault <= FAULT_NONE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                r_ir <= instr;
                r_pc <= r_pc + PC_WIDTH'(1);
            end
            // Counter rests at zero outside MEM, so each access starts from a clean count.
            r_wait <= (r_state == S_MEM) ? r_wait + 8'd1 : 8'd0;
            if (r_fault == FAULT_NONE && w_fault_set != FAULT_NONE) begin
                r_fault <= w_fault_set;
            end
        end
    end

    assign pc      = r_pc;
    assign ir      = r_ir;
    assign fault   = r_fault;
    assign alu_en  = (r_state == S_EXEC);
    assign rf_we   = (r_state == S_WB);
    assign rf_wsel = (r_state == S_WB) && (w_op == OP_LOAD);
    assign mem_req = (r_state == S_MEM);
    assign mem_we  = (r_state == S_MEM) && (w_op == OP_STORE);
    assign busy    = !(r_state inside {S_IDLE, S_PAUSE, S_HALT});
    assign halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a per-instruction cycle-cost model predicts each retire/halt
// event (kind, cycle, ir, pc); a monitor pops and compares whenever the DUT shows one.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam int PCW   = 8;
    localparam int RPC   = 0;
    localparam int TO    = 15;
    localparam int DEPTH = 1 << PCW;

    logic           clk       = 1'b0;
    logic           rst       = 1'b0;
    logic           start     = 1'b0;
    logic           step_mode = 1'b0;
    logic           mem_ack   = 1'b0;
    logic [31:0]    instr;
    logic [PCW-1:0] pc;
    logic [31:0]    ir;
    logic           alu_en, rf_we, rf_wsel, mem_req, mem_we, busy, halted;
    logic [1:0]     fault;

    logic [31:0] imem [DEPTH];
    assign instr = imem[pc];

    cpu_sequencer #(.PC_WIDTH(PCW), .RESET_PC(PCW'(RPC)), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .instr(instr),
        .mem_ack(mem_ack), .pc(pc), .ir(ir), .alu_en(alu_en), .rf_we(rf_we),
        .rf_wsel(rf_wsel), .mem_req(mem_req), .mem_we(mem_we), .busy(busy),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_RF = 0, EV_ST = 1, EV_HALT = 2} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] ir;
        int          cyc;
        int          pc;
        logic        wsel;
        logic [1:0]  flt;
    } ev_t;

    ev_t exp_q[$];
    int  delays[$];
    int  checks = 0;
    int  failures = 0;
    bit  running = 1'b0;
    int  cyc_cnt = 0;
    bit  mon_en = 1'b0;
    bit  halt_seen = 1'b0;
    bit  noise_en = 1'b0;
    int  gap = 1;
    int  pcnt = 0;
    int  dk = 0;
    int  dcnt = 0;
    int  go_cnt = 0;
    int  go_seen = 0;
    int  exp_halt_pc = 0;
    bit  exp_halt = 1'b0;
    int  exp_cycles = 0;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Cycle index: 0 is the FETCH cycle following the launching start edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cyc_cnt <= 0;
        end else if (running) begin
            cyc_cnt <= cyc_cnt + 1;
        end else if (start) begin
            running <= 1'b1;
            cyc_cnt <= 0;
        end
    end

    // Memory responder and start driver, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            mem_ack = 1'b0;
            start   = 1'b0;
            dk      = 0;
            dcnt    = 0;
            pcnt    = 0;
            go_seen = go_cnt;
        end else begin
            if (mem_req) begin
                mem_ack = (dk < delays.size()) && (dcnt == delays[dk]);
                if (mem_ack) begin
                    dk++;
                    dcnt = 0;
                end else begin
                    dcnt++;
                end
            end else begin
                dcnt    = 0;
                mem_ack = noise_en && ($urandom_range(0, 1) == 1);
            end
            if (go_seen != go_cnt) begin
                start   = 1'b1;
                go_seen = go_cnt;
                pcnt    = 0;
            end else if (!running) begin
                start = 1'b0;
            end else if (step_mode) begin
                if (!busy && !halted) begin
                    pcnt++;
                    start = (pcnt == gap);
                    if (start) pcnt = 0;
                end else begin
                    start = 1'b0;
                    pcnt  = 0;
                end
            end else begin
                start = noise_en && ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic compare_ev(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", longint'(k), -1);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", longint'(k), longint'(e.kind));
            check("ev_cycle", cyc_cnt, e.cyc);
            check("ev_ir", ir, e.ir);
            check("ev_pc", pc, e.pc);
            if (k == EV_RF) check("ev_rf_wsel", rf_wsel, e.wsel);
            if (k == EV_HALT) check("ev_fault", fault, e.flt);
        end
    endtask

    always @(negedge clk) begin
        if (!running) begin
            halt_seen = 1'b0;
        end else if (mon_en && !rst) begin
            if (rf_we) compare_ev(EV_RF);
            if (mem_req && mem_ack && mem_we) compare_ev(EV_ST);
            if (halted && !halt_seen) begin
                halt_seen = 1'b1;
                compare_ev(EV_HALT);
            end
        end
    end

    function automatic void push_ev(ev_kind_t k, logic [31:0] w, int c, int p, logic ws, logic [1:0] f);
        ev_t e;
        e.kind = k;
        e.ir   = w;
        e.cyc  = c;
        e.pc   = p;
        e.wsel = ws;
        e.flt  = f;
        exp_q.push_back(e);
    endfunction

    // Walks the program using per-opcode cycle costs; c is the FETCH cycle of the current instruction.
    task automatic build_model(input int max_instr);
        int          p = RPC;
        int          c = 0;
        int          k = 0;
        bit          done = 1'b0;
        bit          retired;
        int          n_wait;
        logic [31:0] w;
        exp_q.delete();
        exp_halt = 1'b0;
        for (int n = 0; n < max_instr && !done; n++) begin
            w       = imem[p];
            p       = (p + 1) % DEPTH;
            retired = 1'b0;
            case (w[5:0])
                OP_ALU: begin
                    push_ev(EV_RF, w, c + 3, p, 1'b0, 2'd0);
                    c += 4;
                    retired = 1'b1;
                end
                OP_LOAD, OP_STORE: begin
                    n_wait = delays[k];
                    k++;
                    if (n_wait > TO) begin
                        push_ev(EV_HALT, w, c + 3 + TO, p, 1'b0, 2'd2);
                        done = 1'b1;
                    end else if (w[5:0] == OP_LOAD) begin
                        push_ev(EV_RF, w, c + 3 + n_wait, p, 1'b1, 2'd0);
                        c += 4 + n_wait;
                        retired = 1'b1;
                    end else begin
                        push_ev(EV_ST, w, c + 2 + n_wait, p, 1'b0, 2'd0);
                        c += 3 + n_wait;
                        retired = 1'b1;
                    end
                end
                OP_HALT: begin
                    push_ev(EV_HALT, w, c + 2, p, 1'b0, 2'd0);
                    done = 1'b1;
                end
                default: begin
                    push_ev(EV_HALT, w, c + 2, p, 1'b0, 2'd1);
                    done = 1'b1;
                end
            endcase
            if (retired && step_mode) c += gap;
            if (done) begin
                exp_halt    = 1'b1;
                exp_halt_pc = p;
            end
        end
        exp_cycles = c + 3 + TO;
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_prog(input string name, input int max_instr, input bit step, input int g);
        int w = 0;
        apply_reset();
        step_mode = step;
        gap       = g;
        noise_en  = 1'b1;
        build_model(max_instr);
        mon_en = 1'b1;
        go_cnt++;
        while (!(exp_q.size() == 0 && (!exp_halt || halt_seen)) && w < exp_cycles + 20) begin
            @(negedge clk);
            w++;
        end
        check({name, "_within_budget"}, w < exp_cycles + 20, 1);
        if (exp_halt) begin
            repeat (12) @(negedge clk);
            check({name, "_halted_hold"}, halted, 1);
            check({name, "_pc_hold"}, pc, exp_halt_pc);
        end
        mon_en = 1'b0;
        check({name, "_no_missing_events"}, exp_q.size(), 0);
    endtask

    function automatic logic [31:0] rand_instr();
        int          r;
        logic [31:0] w;
        logic [5:0]  op;
        r = $urandom_range(0, 99);
        w = $urandom();
        if (r < 40)      op = OP_ALU;
        else if (r < 65) op = OP_LOAD;
        else if (r < 90) op = OP_STORE;
        else if (r < 95) op = OP_HALT;
        else begin
            do op = 6'($urandom_range(0, 63));
            while (op == OP_ALU || op == OP_LOAD || op == OP_STORE || op == OP_HALT);
        end
        w[5:0] = op;
        return w;
    endfunction

    function automatic int rand_delay();
        int r;
        r = $urandom_range(0, 39);
        if (r == 0) return 255;
        if (r <= 2) return TO;
        return $urandom_range(0, 5);
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < DEPTH; i++) imem[i] = {26'd0, OP_HALT};
    endtask

    task automatic set_delays(input int d, input int n);
        delays.delete();
        repeat (n) delays.push_back(d);
    endtask

    task automatic load_demo_program();
        fill_halt();
        imem[0] = 32'h0000_0004;
        imem[1] = 32'h0000_2104;
        imem[2] = 32'h0008_2000;
        imem[3] = 32'h0000_4205;
        imem[4] = 32'h0000_003F;
    endtask

    task automatic reset_in_mem();
        int w = 0;
        apply_reset();
        step_mode = 1'b0;
        noise_en  = 1'b0;
        fill_halt();
        imem[0] = 32'h0000_0004;
        set_delays(255, 1);
        go_cnt++;
        while (!mem_req && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("rstmem_req_raised", mem_req, 1);
        repeat (3) @(negedge clk);
        check("rstmem_req_held", mem_req, 1);
        #2 rst = 1'b1;
        #1;
        check("rstmem_mem_req", mem_req, 0);
        check("rstmem_mem_we", mem_we, 0);
        check("rstmem_rf_we", rf_we, 0);
        check("rstmem_busy", busy, 0);
        check("rstmem_halted", halted, 0);
        check("rstmem_pc", pc, RPC);
        check("rstmem_ir", ir, 0);
        check("rstmem_fault", fault, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmem_idle_after", busy, 0);
        check("rstmem_pc_after", pc, RPC);
    endtask

    initial begin
        fill_halt();
        set_delays(0, 8);
        rst = 1'b1;
        #12;
        check("reset_pc", pc, RPC);
        check("reset_ir", ir, 0);
        check("reset_fault", fault, 0);
        check("reset_busy", busy, 0);
        check("reset_halted", halted, 0);
        check("reset_alu_en", alu_en, 0);
        check("reset_rf_we", rf_we, 0);
        check("reset_rf_wsel", rf_wsel, 0);
        check("reset_mem_req", mem_req, 0);
        check("reset_mem_we", mem_we, 0);

        load_demo_program();
        set_delays(0, 8);
        run_prog("demo_program", 10, 1'b0, 1);

        fill_halt();
        imem[0] = 32'h0000_2104;
        set_delays(3, 1);
        run_prog("load_wait3", 10, 1'b0, 1);

        fill_halt();
        imem[0] = 32'h0000_0004;
        set_delays(255, 1);
        run_prog("mem_timeout", 10, 1'b0, 1);

        fill_halt();
        imem[0] = 32'h0000_0005;
        imem[1] = 32'h0000_2104;
        set_delays(TO, 2);
        run_prog("ack_at_limit", 10, 1'b0, 1);

        fill_halt();
        imem[0] = 32'h0000_0007;
        run_prog("illegal_op", 10, 1'b0, 1);

        load_demo_program();
        set_delays(1, 8);
        run_prog("step_demo", 10, 1'b1, 2);

        for (int i = 0; i < DEPTH; i++) imem[i] = {$urandom()} & 32'hFFFF_FFC0;
        run_prog("pc_wrap", DEPTH + 2, 1'b0, 1);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < DEPTH; i++) imem[i] = rand_instr();
            delays.delete();
            repeat (64) delays.push_back(rand_delay());
            run_prog("random", 40, (t % 3) == 2, $urandom_range(1, 3));
        end

        reset_in_mem();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
